cdb_arbiter: RTL

- Shares the single common data bus (CDB) between three result producers: ALU1, ALU2 and the load/store unit.
- Each source has a small result FIFO. One result per cycle goes onto the CDB, chosen round-robin.
- The CDB feeds the reservation station wake-up lines (rs_update_flag/rs_commit_rename/rs_value) and the ROB value write.
- Each source's FIFO-full state goes back to it as back-pressure (alu1_busy/alu2_busy/lsb_busy).

---
 rtl/cdb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-source result FIFOs (ALU1, ALU2, LSB)
// drained one result per cycle onto the CDB in round-robin order.
module cdb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rob_flush,
   input  logic        alu1_result_flag,
   input  logic [3:0]  alu1_result_rename,
   input  logic [31:0] alu1_result_value,
   output logic        alu1_busy,
   input  logic        alu2_result_flag,
   input  logic [3:0]  alu2_result_rename,
   input  logic [31:0] alu2_result_value,
   output logic        alu2_busy,
   input  logic        lsb_result_flag,
   input  logic [3:0]  lsb_result_rename,
   input  logic [31:0] lsb_result_value,
   output logic        lsb_busy,
   output logic        cdb_flag,
   output logic [3:0]  cdb_rename,
   output logic [31:0] cdb_value,
   output logic [1:0]  cdb_src,
   output logic        overflow_err
);

   localparam int unsigned NSRC  = 3;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned VAL_W = 32;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [TAG_W-1:0] tag_mem [NSRC][FIFO_DEPTH];
   logic [VAL_W-1:0] val_mem [NSRC][FIFO_DEPTH];
   logic [PTR_W-1:0] head    [NSRC];
   logic [PTR_W-1:0] tail    [NSRC];
   logic [CNT_W-1:0] count   [NSRC];
   logic [1:0]       rr;

   logic [NSRC-1:0]  in_flag;
   logic [TAG_W-1:0] in_tag  [NSRC];
   logic [VAL_W-1:0] in_val  [NSRC];
   logic [NSRC-1:0]  full;
   logic [NSRC-1:0]  nonempty;
   logic [NSRC-1:0]  deq;
   logic [NSRC-1:0]  enq;
   logic [NSRC-1:0]  drop;
   logic             grant_valid;
   logic [1:0]       grant_idx;
   logic [TAG_W-1:0] grant_tag;
   logic [VAL_W-1:0] grant_val;

   // (index) mod 3 for a sum of two values in 0..2
   function automatic logic [1:0] wrap3(input logic [2:0] s);
      return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
   endfunction

   // Gather the three producer interfaces into indexable form
   always_comb begin
      in_flag   = {lsb_result_flag, alu2_result_flag, alu1_result_flag};
      in_tag[0] = alu1_result_rename;
      in_tag[1] = alu2_result_rename;
      in_tag[2] = lsb_result_rename;
      in_val[0] = alu1_result_value;
      in_val[1] = alu2_result_value;
      in_val[2] = lsb_result_value;
   end

   // FIFO status flags
   always_comb begin
      full     = '0;
      nonempty = '0;
      for (int i = 0; i < NSRC; i++) begin
         full[i]     = (count[i] == CNT_W'(FIFO_DEPTH));
         nonempty[i] = (count[i] != '0);
      end
   end

   // Round-robin search from rr; the k=0 candidate is written last so it wins
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 2'd0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (nonempty[wrap3({1'b0, rr} + 3'(k))]) begin
            grant_valid = 1'b1;
            grant_idx   = wrap3({1'b0, rr} + 3'(k));
         end
      end
   end

   // Head entry of the granted FIFO
   always_comb begin
      grant_tag = tag_mem[grant_idx][head[grant_idx]];
      grant_val = val_mem[grant_idx][head[grant_idx]];
   end

   // Per-source enqueue/dequeue/drop decisions; a full FIFO being drained accepts
   always_comb begin
      deq  = '0;
      enq  = '0;
      drop = '0;
      for (int i = 0; i < NSRC; i++) begin
         deq[i]  = grant_valid && (grant_idx == 2'(i));
         enq[i]  = in_flag[i] && (!full[i] || deq[i]);
         drop[i] = in_flag[i] && full[i] && !deq[i];
      end
   end

   assign alu1_busy = full[0];
   assign alu2_busy = full[1];
   assign lsb_busy  = full[2];

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NSRC; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
      end else if (rdy) begin
         if (rob_flush) begin
            for (int i = 0; i < NSRC; i++) begin
               head[i]  <= '0;
               tail[i]  <= '0;
               count[i] <= '0;
            end
         end else begin
            for (int i = 0; i < NSRC; i++) begin
               if (enq[i]) tail[i] <= tail[i] + PTR_W'(1);
               if (deq[i]) head[i] <= head[i] + PTR_W'(1);
               if (enq[i] && !deq[i])      count[i] <= count[i] + CNT_W'(1);
               else if (!enq[i] && deq[i]) count[i] <= count[i] - CNT_W'(1);
            end
         end
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      if (rst && rdy && !rob_flush) begin
         for (int i = 0; i < NSRC; i++) begin
            if (enq[i]) begin
               tag_mem[i][tail[i]] <= in_tag[i];
               val_mem[i][tail[i]] <= in_val[i];
            end
         end
      end
   end

   // CDB broadcast register, round-robin pointer and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         cdb_flag     <= 1'b0;
         cdb_rename   <= '0;
         cdb_value    <= '0;
         cdb_src      <= 2'd0;
         rr           <= 2'd0;
         overflow_err <= 1'b0;
      end else if (rdy) begin
         if (rob_flush) begin
            cdb_flag <= 1'b0;
            rr       <= 2'd0;
         end else begin
            cdb_flag <= grant_valid;
            if (grant_valid) begin
               cdb_rename <= grant_tag;
               cdb_value  <= grant_val;
               cdb_src    <= grant_idx;
               rr         <= wrap3({1'b0, grant_idx} + 3'd1);
            end
            if (|drop) overflow_err <= 1'b1;
         end
      end
   end

endmodule
